// File: rtl/tl_log_buffer.sv
// Multi-port TileLink monitor log buffer: per-port stamped FIFOs drained round-robin
// into one registered output. Define TL_LOG_DROP_CNT_EN to add the saturating drop_cnt output.
module tl_log_buffer #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_BEATS = 4,
    localparam int unsigned REC_W     = 104 + 64 * DATA_BEATS,
    localparam int unsigned PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         log_en,
    input  logic [NUM_PORTS-1:0]         in_valid,
    input  logic [NUM_PORTS*REC_W-1:0]   in_rec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REC_W-1:0]             out_rec,
    output logic [PW-1:0]                out_port,
    output logic [63:0]                  out_stamp,
    output logic                         overflow
`ifdef TL_LOG_DROP_CNT_EN
    ,
    output logic [31:0]                  drop_cnt
`endif
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned ENT_W = REC_W + 64;
    localparam logic [AW:0] FULL_XOR = (AW + 1)'(DEPTH);

    logic [ENT_W-1:0] mem_q   [NUM_PORTS][DEPTH];
    logic [ENT_W-1:0] mem_d   [NUM_PORTS][DEPTH];
    logic [AW:0]      wr_ptr_q[NUM_PORTS];
    logic [AW:0]      wr_ptr_d[NUM_PORTS];
    logic [AW:0]      rd_ptr_q[NUM_PORTS];
    logic [AW:0]      rd_ptr_d[NUM_PORTS];
    logic [63:0]      stamp_q, stamp_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic             out_valid_q, out_valid_d;
    logic [REC_W-1:0] out_rec_q, out_rec_d;
    logic [PW-1:0]    out_port_q, out_port_d;
    logic [63:0]      out_stamp_q, out_stamp_d;
    logic             overflow_q, overflow_d;

    logic [NUM_PORTS-1:0] empty_c;
    logic [NUM_PORTS-1:0] full_c;
    logic                 grant_found_c;
    logic [PW-1:0]        grant_c;
    logic                 pop_c;

    // FIFO status and round-robin search starting at rr_q
    always_comb begin
        int unsigned idx;
        idx           = 0;
        grant_found_c = 1'b0;
        grant_c       = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            empty_c[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
            full_c[p]  = ((wr_ptr_q[p] ^ rd_ptr_q[p]) == FULL_XOR);
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!grant_found_c && !empty_c[PW'(idx)]) begin
                grant_found_c = 1'b1;
                grant_c       = PW'(idx);
            end
        end
        pop_c = (!out_valid_q || out_ready) && grant_found_c;
    end

`ifdef TL_LOG_DROP_CNT_EN
    localparam int unsigned CW = $clog2(NUM_PORTS + 1);
    logic [CW-1:0] drop_num_c;
    logic [32:0]   drop_sum_c;
    logic [31:0]   drop_cnt_q, drop_cnt_d;
`endif

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        stamp_d     = stamp_q + 64'd1;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_rec_d   = out_rec_q;
        out_port_d  = out_port_q;
        out_stamp_d = out_stamp_q;
        overflow_d  = overflow_q;
`ifdef TL_LOG_DROP_CNT_EN
        drop_num_c  = '0;
`endif
        if (pop_c) begin
            {out_rec_d, out_stamp_d} = mem_q[grant_c][rd_ptr_q[grant_c][AW-1:0]];
            out_port_d        = grant_c;
            out_valid_d       = 1'b1;
            rd_ptr_d[grant_c] = rd_ptr_q[grant_c] + (AW + 1)'(1);
            rr_d = (grant_c == PW'(NUM_PORTS - 1)) ? '0 : grant_c + PW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // Fullness is taken from the pre-edge pointers, so a same-edge pop never frees a slot
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (in_valid[p] && log_en) begin
                if (!full_c[p]) begin
                    mem_d[p][wr_ptr_q[p][AW-1:0]] = {in_rec[p*REC_W +: REC_W], stamp_q};
                    wr_ptr_d[p] = wr_ptr_q[p] + (AW + 1)'(1);
                end else begin
                    overflow_d = 1'b1;
`ifdef TL_LOG_DROP_CNT_EN
                    drop_num_c = drop_num_c + CW'(1);
`endif
                end
            end
        end
`ifdef TL_LOG_DROP_CNT_EN
        drop_sum_c = {1'b0, drop_cnt_q} + 33'(drop_num_c);
        drop_cnt_d = drop_sum_c[32] ? 32'hFFFF_FFFF : drop_sum_c[31:0];
`endif
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
            end
            stamp_q     <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_rec_q   <= '0;
            out_port_q  <= '0;
            out_stamp_q <= '0;
            overflow_q  <= 1'b0;
`ifdef TL_LOG_DROP_CNT_EN
            drop_cnt_q  <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            stamp_q     <= stamp_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_rec_q   <= out_rec_d;
            out_port_q  <= out_port_d;
            out_stamp_q <= out_stamp_d;
            overflow_q  <= overflow_d;
`ifdef TL_LOG_DROP_CNT_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_rec   = out_rec_q;
    assign out_port  = out_port_q;
    assign out_stamp = out_stamp_q;
    assign overflow  = overflow_q;
`ifdef TL_LOG_DROP_CNT_EN
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: doc/tl_log_buffer.md
TL_LOG_BUFFER -- requirements
Module: tl_log_buffer

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of independent TileLink monitor input ports (1..16).
REQ-002 SHALL have parameter DEPTH, default 8, entries per port FIFO (power of 2, 2..64).
REQ-003 SHALL have parameter DATA_BEATS, default 4, number of 64-bit data words per record (1..8); REC_W = 104 + 64*DATA_BEATS.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port log_en  input  1  global capture enable.
REQ-007 SHALL have port in_valid  input  NUM_PORTS  per-port record-present strobe; no backpressure.
REQ-008 SHALL have port in_rec  input  NUM_PORTS*REC_W  packed records, port p at bits [p*REC_W +: REC_W]; within a record, LSB first: channel 8, opcode 8, param 8, source 8, sink 8, address 64, data_0..data_N 64 each.
REQ-009 SHALL have port out_valid  output  1  output record valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the record when high with out_valid.
REQ-011 SHALL have port out_rec  output  REC_W  drained record.
REQ-012 SHALL have port out_port  output  max(1,clog2(NUM_PORTS))  originating port index.
REQ-013 SHALL have port out_stamp  output  64  cycle stamp captured at enqueue.
REQ-014 SHALL have port overflow  output  1  sticky: some record was dropped since reset.

Function
REQ-015 SHALL keep a 64-bit free-running stamp counter incremented every cycle, wrapping from all-ones to 0.
REQ-016 SHALL enqueue {in_rec[p], stamp} into FIFO p on an edge where in_valid[p] && log_en && FIFO p is not full.
REQ-017 SHALL evaluate fullness before any same-cycle dequeue; a write to a full FIFO is dropped even if that FIFO is dequeued on the same edge.
REQ-018 SHALL set overflow on any dropped write; records with log_en low are ignored and are not drops.
REQ-019 SHALL load the output register when (!out_valid || out_ready) and at least one FIFO is non-empty, popping the granted FIFO on the same edge.
REQ-020 SHALL grant round-robin: search starts at the port after the last granted port; after reset, port 0 has highest priority.
REQ-021 SHALL hold out_rec, out_port and out_stamp stable while out_valid && !out_ready.
REQ-022 SHALL deassert out_valid after an accepted transfer when no FIFO is non-empty.
REQ-023 SHALL have a minimum latency of 2 edges: a record sampled at edge E0 is on the output after edge E1.
REQ-024 SHALL sustain one record per cycle while out_ready is held high.
REQ-025 SHALL drain normally while log_en is low.

Reset
REQ-026 SHALL on reset clear every FIFO pointer, the stamp counter, the round-robin pointer, overflow and out_valid; out_rec, out_port and out_stamp reset to 0.
REQ-027 SHALL discard buffered and in-flight records when reset is asserted mid-operation; no enqueue occurs on a reset edge.

Configuration
REQ-028 SHALL, with TL_LOG_DROP_CNT_EN defined, add output drop_cnt (32 bits) counting dropped records per REQ-017/018, saturating at 0xFFFFFFFF, reset to 0; simultaneous drops on k ports add k.
REQ-029 SHALL, without TL_LOG_DROP_CNT_EN, omit the drop_cnt port and its logic; all other behaviour is unchanged.

Verification
REQ-030 SHALL test single record: port 2 valid at stamp 10, out_ready=1 -> out_valid after 2 edges, out_port=2, out_stamp=10, fields intact.
REQ-031 SHALL test round-robin: all 4 ports valid in one cycle, out_ready=1 -> outputs in port order 0,1,2,3 on consecutive cycles; the next burst starts at port 0 after port 3.
REQ-032 SHALL test overflow: DEPTH=8, out_ready=0, port 0 valid for 12 cycles -> 8 buffered, overflow=1, drop_cnt=3 (macro on; the first record sits in the output register).
REQ-033 SHALL test backpressure: out_ready toggling 1/0 -> no record lost or duplicated, and outputs stay stable while stalled.
REQ-034 SHALL test the enable gate and reset: log_en=0 with valid inputs -> nothing enqueued and overflow=0; reset while 5 records are buffered -> out_valid=0 on the next cycle, stamp=0, nothing drains afterward.
